// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a byte stream into 32-bit words and writes them to instruction memory from address 0 (optional LOADER_CHECKSUM_EN adds a running word sum)
module instr_mem_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic              error
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
  localparam logic [ADDR_W:0] MAXW = MAX_WORDS[ADDR_W:0];
  state_t state;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W-1:0] widx;
  logic [1:0] bidx;
  logic [31:0] shift;
  logic we_q;
  logic hs;
  assign hs = byte_valid & byte_ready;
  // abort in the write cycle must kill that cycle's write, so it gates the registered strobe directly
  assign mem_we = we_q & ~abort;
  // load sequencer: start/length check, byte packing, one-cycle word write, abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      widx       <= '0;
      bidx       <= '0;
      shift      <= '0;
      we_q       <= 1'b0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          cnt   <= word_count;
          widx  <= '0;
          bidx  <= '0;
          done  <= 1'b0;
          error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
          checksum <= '0;
`endif
          if (word_count == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (word_count > MAXW) begin
            state <= DONE;
            done  <= 1'b1;
            error <= 1'b1;
          end else begin
            state      <= RECV;
            busy       <= 1'b1;
            byte_ready <= 1'b1;
          end
        end
        RECV: if (abort) begin
          state      <= IDLE;
          busy       <= 1'b0;
          byte_ready <= 1'b0;
        end else if (hs) begin
          shift[{~bidx, 3'b111} -: 8] <= byte_in;
          bidx <= bidx + 2'd1;
          if (bidx == 2'd3) begin
            state      <= WRITE;
            byte_ready <= 1'b0;
            we_q       <= 1'b1;
            mem_addr   <= widx;
            mem_data   <= {shift[31:8], byte_in};
          end
        end
        WRITE: begin
          we_q <= 1'b0;
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            checksum <= checksum + mem_data;
`endif
            if ({1'b0, widx} == cnt - 1'b1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= RECV;
              widx       <= widx + 1'b1;
              bidx       <= '0;
              byte_ready <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized loads checked against a byte-to-word memory image model
module tb_instr_mem_loader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, byte_valid = 1'b0;
  logic [10:0] word_count = '0;
  logic [7:0] byte_in = '0;
  logic byte_ready, mem_we, busy, done, error;
  logic [9:0] mem_addr;
  logic [31:0] mem_data;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  logic [31:0] dut_mem [0:1023];
  logic [31:0] model_mem [0:1023];
  logic [31:0] model_sum;
  logic [7:0] src [$];
  int n_we = 0, n_chk = 0, n_pass = 0;

  instr_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done), .error(error)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    #1;
    if (mem_we === 1'b1) begin
      dut_mem[mem_addr] = mem_data;
      n_we++;
    end
    @(negedge clk);
  endtask

  task automatic load(input int n, input int gmin, input int gmax, input int ab_w, input int ab_k, input bit poke);
    int base, t;
    logic [31:0] w32;
    logic [7:0] b;
    base = n_we;
    model_sum = 0;
    word_count = 11'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (n == 0 || n > 1024) begin
      chk("done_nil", done, 1);
      chk("err_nil", error, n > 1024);
      chk("busy_nil", busy, 0);
      byte_valid = 1'b1;
      byte_in = 8'hAA;
      repeat (3) begin
        tick();
        chk("rdy_nil", byte_ready, 0);
      end
      byte_valid = 1'b0;
      chk("we_nil", n_we - base, 0);
      return;
    end
    chk("busy_start", busy, 1);
    for (int w = 0; w < n; w++) begin
      w32 = 0;
      for (int k = 0; k < 4; k++) begin
        b = (src.size() > 0) ? src.pop_front() : 8'($urandom);
        if (w == ab_w && k == ab_k) begin
          abort = 1'b1;
          byte_valid = 1'b1;
          byte_in = b;
          tick();
          abort = 1'b0;
          byte_valid = 1'b0;
          chk("abort_busy", busy, 0);
          chk("abort_done", done, 0);
          chk("abort_we", n_we - base, (k == 0 && w > 0) ? w - 1 : w);
          return;
        end
        w32 = w32 * 256 + 32'(b);
        byte_in = b;
        byte_valid = 1'b1;
        if (poke && w == 0 && k == 1) begin
          start = 1'b1;
          word_count = 11'd0;
        end
        t = 0;
        while (!byte_ready && t < 50) begin
          tick();
          t++;
        end
        if (t == 50) begin
          chk("rdy_timeout", 0, 1);
          byte_valid = 1'b0;
          return;
        end
        tick();
        byte_valid = 1'b0;
        start = 1'b0;
        if (k < 3) repeat ($urandom_range(gmax, gmin)) tick();
      end
      model_mem[w] = w32;
      model_sum += w32;
      chk("we", mem_we, 1);
      chk("addr", mem_addr, w);
      chk("data", mem_data, w32);
      chk("rdy_wr", byte_ready, 0);
    end
    tick();
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("err", error, 0);
    chk("we_count", n_we - base, n);
    for (int w = 0; w < n; w++) chk("mem", dut_mem[w], model_mem[w]);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", checksum, model_sum);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, aw, ak;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_rdy", byte_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    rst_n = 1'b1;
    tick();
    src = '{8'h8C, 8'h22, 8'h00, 8'h04};
    load(1, 0, 0, -1, -1, 0);
    chk("single_word", dut_mem[0], 32'h8C220004);
    src = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h22, 8'h18, 8'h20, 8'h08, 8'h00, 8'h00, 8'h00};
    load(3, 2, 2, -1, -1, 0);
    chk("w2", dut_mem[2], 32'h08000000);
    load(0, 0, 0, -1, -1, 0);
    load(1025, 0, 0, -1, -1, 0);
    load(2, 0, 1, 1, 2, 0);
    load(1, 0, 1, -1, -1, 0);
    load(3, 0, 2, 2, 0, 0);
    load(4, 1, 3, -1, -1, 1);
    src = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02};
    load(2, 0, 0, -1, -1, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum_wrap", checksum, 32'h1);
`endif
    repeat (10) begin
      n = $urandom_range(6, 1);
      aw = ($urandom_range(2, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
      ak = $urandom_range(3, 0);
      load(n, 0, $urandom_range(3, 0), aw, ak, $urandom_range(1, 0) == 1);
      repeat ($urandom_range(2, 0)) tick();
    end
    load(1024, 0, 0, -1, -1, 0);
    chk("last_addr", mem_addr, 10'd1023);
    word_count = 11'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    byte_valid = 1'b1;
    byte_in = 8'h5A;
    repeat (2) tick();
    chk("mid_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rdy", byte_ready, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_data", mem_data, 0);
    chk("arst_done", done, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    load(2, 0, 1, -1, -1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
